crc_rx_check: RTL and testbench

CRC_RX_CHECK -- requirements
Module: crc_rx_check

---
 rtl/crc_rx_check.sv | 126 ++++++++++++
 tb/tb_crc_rx_check.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/crc_rx_check.sv
// Receive-side CRC checker: folds each flit into a running CRC in one cycle and
// compares the computed CRC against the FCS carried in the tail of the last flit.
module crc_rx_check #(
  parameter int                   DWIDTH    = 512,
  parameter int                   CRC_WIDTH = 32,
  parameter logic [CRC_WIDTH-1:0] CRC_POLY  = 32'h04C11DB7,
  parameter logic [CRC_WIDTH-1:0] INIT      = 32'hFFFFFFFF,
  parameter logic [CRC_WIDTH-1:0] XOR_OUT   = 32'hFFFFFFFF,
  parameter bit                   REFIN     = 1'b1,
  parameter bit                   REFOUT    = 1'b1
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [DWIDTH-1:0]    din,
  input  logic                 flitEn,
  input  logic                 dlast,
  input  logic                 clr_cnt,
  output logic                 chk_vld,
  output logic                 chk_pass,
  output logic [CRC_WIDTH-1:0] crc_rx,
  output logic [CRC_WIDTH-1:0] crc_calc,
  output logic [15:0]          msg_cnt,
  output logic [15:0]          err_cnt
);

  localparam int NBYTES    = DWIDTH / 8;
  localparam int FCS_BYTES = CRC_WIDTH / 8;
  localparam int PAY_BYTES = NBYTES - FCS_BYTES;

  typedef enum logic {IDLE, IN_MSG} state_t;

  state_t               state;
  logic [CRC_WIDTH-1:0] crc_reg;
  logic [CRC_WIDTH-1:0] crc_base;
  logic [CRC_WIDTH-1:0] crc_full;
  logic [CRC_WIDTH-1:0] crc_pay;
  logic [CRC_WIDTH-1:0] crc_final;
  logic [CRC_WIDTH-1:0] fcs;
  logic                 pass_now;
  logic                 last_flit;

  function automatic logic [7:0] reflect8(input logic [7:0] b);
    logic [7:0] r;
    for (int i = 0; i < 8; i++) r[i] = b[7-i];
    return r;
  endfunction

  function automatic logic [CRC_WIDTH-1:0] reflect_crc(input logic [CRC_WIDTH-1:0] c);
    logic [CRC_WIDTH-1:0] r;
    for (int i = 0; i < CRC_WIDTH; i++) r[i] = c[CRC_WIDTH-1-i];
    return r;
  endfunction

  // Bit-serial MSB-first update, unrolled across the leading nbytes bytes of the flit.
  function automatic logic [CRC_WIDTH-1:0] crc_update(input logic [CRC_WIDTH-1:0] c_in,
                                                      input logic [DWIDTH-1:0]    d,
                                                      input int                   nbytes);
    logic [CRC_WIDTH-1:0] c;
    logic [7:0]           byte_v;
    logic                 fb;
    c = c_in;
    for (int b = 0; b < NBYTES; b++) begin
      if (b < nbytes) begin
        byte_v = d[DWIDTH-1-8*b -: 8];
        if (REFIN) byte_v = reflect8(byte_v);
        for (int i = 7; i >= 0; i--) begin
          fb = c[CRC_WIDTH-1] ^ byte_v[i];
          c  = {c[CRC_WIDTH-2:0], 1'b0};
          if (fb) c = c ^ CRC_POLY;
        end
      end
    end
    return c;
  endfunction

  always_comb begin
    crc_base  = (state == IDLE) ? INIT : crc_reg;
    crc_full  = crc_update(crc_base, din, NBYTES);
    crc_pay   = crc_update(crc_base, din, PAY_BYTES);
    crc_final = (REFOUT ? reflect_crc(crc_pay) : crc_pay) ^ XOR_OUT;
    fcs       = din[CRC_WIDTH-1:0];
    pass_now  = (fcs == crc_final);
    last_flit = flitEn & dlast;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      crc_reg  <= INIT;
      chk_vld  <= 1'b0;
      chk_pass <= 1'b0;
      crc_rx   <= '0;
      crc_calc <= '0;
    end else begin
      chk_vld <= 1'b0;
      if (flitEn) begin
        if (dlast) begin
          state    <= IDLE;
          crc_reg  <= INIT;
          chk_vld  <= 1'b1;
          chk_pass <= pass_now;
          crc_rx   <= fcs;
          crc_calc <= crc_final;
        end else begin
          state   <= IN_MSG;
          crc_reg <= crc_full;
        end
      end
    end
  end

  // Counters move on the same edge that raises chk_vld, so they agree with the strobe.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      msg_cnt <= '0;
      err_cnt <= '0;
    end else if (clr_cnt) begin
      msg_cnt <= '0;
      err_cnt <= '0;
    end else if (last_flit) begin
      if (msg_cnt != 16'hFFFF) msg_cnt <= msg_cnt + 16'd1;
      if (!pass_now && err_cnt != 16'hFFFF) err_cnt <= err_cnt + 16'd1;
    end
  end

endmodule

// File: tb/tb_crc_rx_check.sv
// Directed bench for crc_rx_check: a 104-bit instance for CRC content and framing,
// a 32-bit instance for empty payloads and counter saturation/clear.
module tb_crc_rx_check;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [103:0] din_a = '0;
  logic         en_a = 1'b0, dlast_a = 1'b0, clr_a = 1'b0;
  logic         vld_a, pass_a;
  logic [31:0]  rx_a, calc_a;
  logic [15:0]  msg_a, err_a;

  logic [31:0]  din_b = '0;
  logic         en_b = 1'b0, dlast_b = 1'b0, clr_b = 1'b0;
  logic         vld_b, pass_b;
  logic [31:0]  rx_b, calc_b;
  logic [15:0]  msg_b, err_b;

  crc_rx_check #(.DWIDTH(104)) dut_a (
    .clk(clk), .rst_n(rst_n), .din(din_a), .flitEn(en_a), .dlast(dlast_a),
    .clr_cnt(clr_a), .chk_vld(vld_a), .chk_pass(pass_a), .crc_rx(rx_a),
    .crc_calc(calc_a), .msg_cnt(msg_a), .err_cnt(err_a));

  crc_rx_check #(.DWIDTH(32)) dut_b (
    .clk(clk), .rst_n(rst_n), .din(din_b), .flitEn(en_b), .dlast(dlast_b),
    .clr_cnt(clr_b), .chk_vld(vld_b), .chk_pass(pass_b), .crc_rx(rx_b),
    .crc_calc(calc_b), .msg_cnt(msg_b), .err_cnt(err_b));

  int checks = 0;
  int errors = 0;

  typedef struct {
    logic [103:0] din;
    logic         exp_pass;
    logic [31:0]  exp_calc;
    logic [31:0]  exp_rx;
    logic [15:0]  exp_msg;
    logic [15:0]  exp_err;
  } vec_t;

  vec_t vecs[4];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: standard reflected CRC-32 (shift-right form, poly EDB88320).
  function automatic logic [31:0] crc_ref(input logic [7:0] q[$]);
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (q[i]) begin
      c = c ^ {24'h0, q[i]};
      for (int k = 0; k < 8; k++) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return c ^ 32'hFFFFFFFF;
  endfunction

  task automatic drive_a(input logic [103:0] d, input logic l, input logic e, input logic c);
    @(negedge clk);
    din_a = d; dlast_a = l; en_a = e; clr_a = c;
    @(posedge clk);
    #1;
  endtask

  task automatic drive_b(input logic [31:0] d, input logic l, input logic e, input logic c);
    @(negedge clk);
    din_b = d; dlast_b = l; en_b = e; clr_b = c;
    @(posedge clk);
    #1;
  endtask

  // Sends payload + FCS over 13-byte flits; optional random idle gaps carry junk din/dlast.
  task automatic send_msg_a(input logic [7:0] pl[$], input logic corrupt, input bit gaps,
                            input string tag);
    logic [7:0]   st[$];
    logic [31:0]  good, fcs;
    logic [103:0] flit;
    int           nflits;
    bit           last;
    good = crc_ref(pl);
    fcs  = good ^ {31'h0, corrupt};
    st   = pl;
    for (int i = 3; i >= 0; i--) st.push_back(fcs[8*i +: 8]);
    nflits = st.size() / 13;
    for (int f = 0; f < nflits; f++) begin
      if (gaps) begin
        while ($urandom_range(1, 0) == 1) begin
          drive_a({$urandom, $urandom, $urandom, $urandom}, 1'b1, 1'b0, 1'b0);
          chk({tag, "_gap_vld"}, vld_a, 0);
        end
      end
      for (int b = 0; b < 13; b++) flit[103-8*b -: 8] = st[13*f + b];
      last = (f == nflits - 1);
      drive_a(flit, last, 1'b1, 1'b0);
      chk({tag, "_vld"}, vld_a, last);
      if (last) begin
        chk({tag, "_pass"}, pass_a, !corrupt);
        chk({tag, "_calc"}, calc_a, good);
        chk({tag, "_rx"}, rx_a, fcs);
      end
    end
  endtask

  function automatic void rand_payload(output logic [7:0] q[$], input int n);
    q = {};
    for (int i = 0; i < n; i++) q.push_back(8'($urandom));
  endfunction

  initial begin
    logic [7:0]  pl[$];
    logic [31:0] fcs_v;
    logic [103:0] flit;

    pl = '{8'h30, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    vecs[0] = '{104'h313233343536373839_CBF43926, 1'b1, 32'hCBF43926, 32'hCBF43926, 16'd1, 16'd0};
    vecs[1] = '{104'h303233343536373839_CBF43926, 1'b0, crc_ref(pl), 32'hCBF43926, 16'd2, 16'd1};
    vecs[2] = '{104'h313233343536373839_00000000, 1'b0, 32'hCBF43926, 32'h00000000, 16'd3, 16'd2};
    pl = '{8'h61, 8'h62, 8'h63, 8'h64, 8'h65, 8'h66, 8'h67, 8'h68, 8'h69};
    fcs_v = crc_ref(pl);
    vecs[3] = '{{72'h616263646566676869, fcs_v}, 1'b1, fcs_v, fcs_v, 16'd4, 16'd2};

    repeat (3) @(posedge clk);
    #1;
    chk("rst_vld", vld_a, 0);
    chk("rst_calc", calc_a, 0);
    chk("rst_msg", msg_a, 0);
    chk("rst_err", err_a, 0);
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 4; i++) begin
      drive_a(vecs[i].din, 1'b1, 1'b1, 1'b0);
      $display("vec %0d: din=%h vld=%b pass=%b calc=%h msg=%0d err=%0d",
               i, vecs[i].din, vld_a, pass_a, calc_a, msg_a, err_a);
      chk($sformatf("vec%0d_vld", i), vld_a, 1);
      chk($sformatf("vec%0d_pass", i), pass_a, vecs[i].exp_pass);
      chk($sformatf("vec%0d_calc", i), calc_a, vecs[i].exp_calc);
      chk($sformatf("vec%0d_rx", i), rx_a, vecs[i].exp_rx);
      chk($sformatf("vec%0d_msg", i), msg_a, vecs[i].exp_msg);
      chk($sformatf("vec%0d_err", i), err_a, vecs[i].exp_err);
      drive_a(~vecs[i].din, 1'b1, 1'b0, 1'b0);
      chk($sformatf("vec%0d_idle_vld", i), vld_a, 0);
      chk($sformatf("vec%0d_hold_calc", i), calc_a, vecs[i].exp_calc);
    end

    for (int m = 0; m < 3; m++) begin
      rand_payload(pl, 35);
      send_msg_a(pl, 1'b0, 1'b1, $sformatf("gap%0d", m));
      $display("gap msg %0d: calc=%h pass=%b", m, calc_a, pass_a);
    end

    rand_payload(pl, 22); send_msg_a(pl, 1'b0, 1'b0, "b2b0");
    rand_payload(pl, 35); send_msg_a(pl, 1'b0, 1'b0, "b2b1");
    rand_payload(pl, 9);  send_msg_a(pl, 1'b1, 1'b0, "b2b2");
    rand_payload(pl, 22); send_msg_a(pl, 1'b0, 1'b0, "b2b3");
    $display("b2b done: msg=%0d err=%0d", msg_a, err_a);
    chk("b2b_msg", msg_a, 16'd11);
    chk("b2b_err", err_a, 16'd3);

    rand_payload(pl, 35);
    for (int f = 0; f < 2; f++) begin
      for (int b = 0; b < 13; b++) flit[103-8*b -: 8] = pl[13*f + b];
      drive_a(flit, 1'b0, 1'b1, 1'b0);
      chk("abort_vld", vld_a, 0);
    end
    @(negedge clk);
    en_a = 1'b0;
    rst_n = 1'b0;
    #1;
    chk("abort_rst_calc", calc_a, 0);
    chk("abort_rst_msg", msg_a, 0);
    @(negedge clk);
    rst_n = 1'b1;
    for (int k = 0; k < 2; k++) begin
      drive_a(104'h0, 1'b1, 1'b0, 1'b0);
      chk("abort_post_vld", vld_a, 0);
    end
    rand_payload(pl, 35);
    send_msg_a(pl, 1'b0, 1'b0, "after_abort");
    chk("after_abort_msg", msg_a, 16'd1);
    chk("after_abort_err", err_a, 16'd0);
    $display("abort: msg=%0d pass=%b", msg_a, pass_a);

    drive_b(32'h0, 1'b1, 1'b1, 1'b0);
    $display("empty: vld=%b pass=%b calc=%h", vld_b, pass_b, calc_b);
    chk("empty_vld", vld_b, 1);
    chk("empty_pass", pass_b, 1);
    chk("empty_calc", calc_b, 32'h0);
    drive_b(32'h0, 1'b0, 1'b1, 1'b1);
    chk("clr_msg", msg_b, 0);

    for (int n = 0; n < 65534; n++) drive_b(32'h1, 1'b1, 1'b1, 1'b0);
    chk("sat_msg_fffe", msg_b, 16'hFFFE);
    chk("sat_err_fffe", err_b, 16'hFFFE);
    for (int n = 0; n < 3; n++) begin
      drive_b(32'h1, 1'b1, 1'b1, 1'b0);
      $display("sat %0d: msg=%h err=%h", n, msg_b, err_b);
      chk($sformatf("sat%0d_msg", n), msg_b, 16'hFFFF);
      chk($sformatf("sat%0d_err", n), err_b, 16'hFFFF);
    end
    drive_b(32'h1, 1'b1, 1'b1, 1'b1);
    chk("clr_evt_vld", vld_b, 1);
    chk("clr_evt_msg", msg_b, 0);
    chk("clr_evt_err", err_b, 0);
    drive_b(32'h1, 1'b1, 1'b1, 1'b0);
    chk("post_clr_msg", msg_b, 1);
    chk("post_clr_err", err_b, 1);
    drive_b(32'h0, 1'b0, 1'b0, 1'b0);
    chk("post_clr_idle_vld", vld_b, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
